// File: rtl/debug_loader_ctrl.sv
// Byte-command controller between the UART and the fetch stage. It loads programs
// into instruction memory, gates the pipeline for run/single-step, and reports completion.
module debug_loader_ctrl #(
   parameter int                  len_data  = 32,
   parameter int                  len_addr  = 7,
   parameter logic [len_data-1:0] halt_word = {len_data{1'b1}}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          rx_byte,
   input  logic                rx_valid,
   input  logic                halt_flag,
   input  logic                tx_ready,
   output logic [7:0]          tx_byte,
   output logic                tx_valid,
   output logic                debug_flag,
   output logic [len_addr-1:0] addr_debug,
   output logic [len_data-1:0] ins_to_mem,
   output logic                wea_ram_inst,
   output logic                stall_flag
);
   localparam int nbytes = len_data / 8;
   localparam int bw     = (nbytes > 1) ? $clog2(nbytes) : 1;
   localparam logic [bw-1:0] last_byte = bw'(nbytes - 1);

   localparam logic [7:0] cmd_load  = 8'h4C;
   localparam logic [7:0] cmd_run   = 8'h43;
   localparam logic [7:0] cmd_step  = 8'h53;
   localparam logic [7:0] cmd_halt  = 8'h48;
   localparam logic [7:0] cmd_next  = 8'h4E;
   localparam logic [7:0] cmd_end   = 8'h45;
   localparam logic [7:0] rep_halt  = 8'hD0;
   localparam logic [7:0] rep_abort = 8'hAB;

   typedef enum logic [2:0] {
      IDLE, LOAD, WRITE, RUN, STEP, STEP_PULSE, REPORT
   } state_t;

   state_t            state_reg, state_next;
   logic [bw-1:0]     byte_cnt;
   logic [len_addr:0] word_cnt;
   logic [len_addr:0] word_cnt_inc;
   logic              load_done;

   assign word_cnt_inc = word_cnt + 1'b1;
   // A load ends on the halt word or once the last memory address has been written.
   assign load_done    = (ins_to_mem == halt_word) || (addr_debug == '1);

   always_ff @(posedge clk) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next   = state_reg;
      debug_flag   = 1'b1;
      stall_flag   = 1'b1;
      wea_ram_inst = 1'b0;
      tx_valid     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rx_valid) begin
               if (rx_byte == cmd_load)      state_next = LOAD;
               else if (rx_byte == cmd_run)  state_next = RUN;
               else if (rx_byte == cmd_step) state_next = STEP;
            end
         end
         LOAD: begin
            if (rx_valid && byte_cnt == last_byte) state_next = WRITE;
         end
         WRITE: begin
            wea_ram_inst = 1'b1;
            state_next   = load_done ? REPORT : LOAD;
         end
         RUN: begin
            debug_flag = 1'b0;
            stall_flag = halt_flag;
            if (halt_flag || (rx_valid && rx_byte == cmd_halt)) state_next = REPORT;
         end
         STEP: begin
            debug_flag = 1'b0;
            if (halt_flag) state_next = REPORT;
            else if (rx_valid && rx_byte == cmd_next) state_next = STEP_PULSE;
            else if (rx_valid && rx_byte == cmd_end)  state_next = REPORT;
         end
         STEP_PULSE: begin
            debug_flag = 1'b0;
            stall_flag = halt_flag;
            state_next = halt_flag ? REPORT : STEP;
         end
         REPORT: begin
            tx_valid = 1'b1;
            if (tx_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ins_to_mem <= '0;
         addr_debug <= '0;
         byte_cnt   <= '0;
         word_cnt   <= '0;
         tx_byte    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (rx_valid && rx_byte == cmd_load) begin
                  addr_debug <= '0;
                  word_cnt   <= '0;
                  byte_cnt   <= '0;
               end
            end
            LOAD: begin
               if (rx_valid) begin
                  ins_to_mem <= (ins_to_mem << 8) | len_data'(rx_byte);
                  byte_cnt   <= (byte_cnt == last_byte) ? '0 : byte_cnt + 1'b1;
               end
            end
            WRITE: begin
               addr_debug <= addr_debug + 1'b1;
               word_cnt   <= word_cnt_inc;
               if (load_done) tx_byte <= 8'(word_cnt_inc);
            end
            RUN: begin
               if (halt_flag)                               tx_byte <= rep_halt;
               else if (rx_valid && rx_byte == cmd_halt)    tx_byte <= rep_abort;
            end
            STEP: begin
               if (halt_flag)                               tx_byte <= rep_halt;
               else if (rx_valid && rx_byte == cmd_end)     tx_byte <= rep_abort;
            end
            STEP_PULSE: begin
               if (halt_flag) tx_byte <= rep_halt;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_debug_loader_ctrl.sv
// Directed/randomized bench for debug_loader_ctrl: program loads, run, single-step,
// report handshake and reset, checked against a behavioural model of the command protocol.
module tb_debug_loader_ctrl;
   localparam int LD = 32;
   localparam int LA = 7;
   localparam int DEPTH = 2 ** LA;
   localparam logic [LD-1:0] HALT = 32'hFFFFFFFF;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic          rx_valid = 1'b0;
   logic          halt_flag = 1'b0;
   logic          tx_ready = 1'b0;
   logic [7:0]    tx_byte;
   logic          tx_valid;
   logic          debug_flag;
   logic [LA-1:0] addr_debug;
   logic [LD-1:0] ins_to_mem;
   logic          wea_ram_inst;
   logic          stall_flag;

   always #5 clk = ~clk;

   debug_loader_ctrl #(.len_data(LD), .len_addr(LA), .halt_word(HALT)) dut (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .halt_flag(halt_flag), .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_valid(tx_valid),
      .debug_flag(debug_flag), .addr_debug(addr_debug), .ins_to_mem(ins_to_mem),
      .wea_ram_inst(wea_ram_inst), .stall_flag(stall_flag)
   );

   int checks = 0;
   int errors = 0;
   logic [LA+LD-1:0] wr_q[$];
   int stall_low = 0;
   logic [LD-1:0] prog[$];

   // Observed memory writes and count of cycles with the pipeline released.
   always @(negedge clk) begin
      if (wea_ram_inst) wr_q.push_back({addr_debug, ins_to_mem});
      if (!stall_flag) stall_low <= stall_low + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      rx_byte = b; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   function automatic logic [LD-1:0] rand_word();
      logic [LD-1:0] w;
      w = $urandom;
      if (w == HALT) w = '0;
      return w;
   endfunction

   task automatic wait_report(input logic [7:0] exp);
      bit seen = 0;
      int k;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = tx_valid;
      end
      chk("tx_valid_seen", 64'(seen), 64'd1);
      chk("tx_byte", tx_byte, exp);
      k = $urandom_range(0, 3);
      repeat (k) begin
         @(negedge clk);
         chk("tx_hold_valid", tx_valid, 1);
         chk("tx_hold_byte", tx_byte, exp);
      end
      @(posedge clk); #1 tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;
      @(negedge clk);
      chk("post_tx_valid", tx_valid, 0);
      chk("post_debug", debug_flag, 1);
      chk("post_stall", stall_flag, 1);
   endtask

   // Model: words are written to consecutive addresses from 0; the load stops at the
   // halt word or at the last address, and the report byte is the number of words written.
   task automatic run_load();
      int base, stop;
      logic [LA+LD-1:0] e;
      base = wr_q.size();
      stop = prog.size() - 1;
      for (int i = 0; i < prog.size(); i++) begin
         if (prog[i] == HALT || i == DEPTH - 1) begin
            stop = i;
            break;
         end
      end
      send(8'h4C);
      for (int i = 0; i <= stop; i++)
         for (int b = LD / 8 - 1; b >= 0; b--) send(prog[i][8*b +: 8]);
      wait_report(8'(stop + 1));
      chk("wr_count", 64'(wr_q.size() - base), 64'(stop + 1));
      for (int i = 0; i <= stop && base + i < wr_q.size(); i++) begin
         e = wr_q[base + i];
         chk("wr_addr", e[LA+LD-1:LD], 64'(i % DEPTH));
         chk("wr_data", e[LD-1:0], prog[i]);
      end
      chk("addr_after_load", addr_debug, 64'((stop + 1) % DEPTH));
      $display("load: %0d words written, report %0h", stop + 1, 8'(stop + 1));
   endtask

   // mode 0: halt_flag ends the run; 1: 'H' aborts; 2: both in the same cycle.
   task automatic run_mode(input int d, input int mode);
      int s0;
      s0 = stall_low;
      send(8'h43);
      repeat (d) begin
         @(negedge clk);
         chk("run_stall", stall_flag, 0);
         chk("run_debug", debug_flag, 0);
         @(posedge clk); #1;
      end
      if (mode != 1) halt_flag = 1'b1;
      if (mode != 0) begin rx_byte = 8'h48; rx_valid = 1'b1; end
      @(negedge clk);
      chk("run_end_stall", stall_flag, (mode == 1) ? 0 : 1);
      @(posedge clk); #1;
      halt_flag = 1'b0; rx_valid = 1'b0;
      @(negedge clk);
      chk("run_report_stall", stall_flag, 1);
      wait_report((mode == 1) ? 8'hAB : 8'hD0);
      chk("run_low_cycles", 64'(stall_low - s0), 64'(d + ((mode == 1) ? 1 : 0)));
      $display("run: mode %0d after %0d cycles, report %0h", mode, d, tx_byte);
   endtask

   task automatic run_step(input int n, input bit halt_end);
      int s0;
      s0 = stall_low;
      send(8'h53);
      @(negedge clk);
      chk("step_stall", stall_flag, 1);
      chk("step_debug", debug_flag, 0);
      for (int i = 0; i < n; i++) send(8'h4E);
      if (halt_end) begin
         halt_flag = 1'b1;
         @(negedge clk);
         chk("step_pulse_halt_stall", stall_flag, 1);
         @(posedge clk); #1 halt_flag = 1'b0;
         wait_report(8'hD0);
      end else begin
         send(8'h45);
         wait_report(8'hAB);
      end
      chk("step_low_cycles", 64'(stall_low - s0), 64'(halt_end ? n - 1 : n));
      $display("step: %0d pulses, halt_end=%0d", n, halt_end);
   endtask

   initial begin
      int n, base;
      logic [7:0] b;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_debug", debug_flag, 1);
      chk("rst_stall", stall_flag, 1);
      chk("rst_wea", wea_ram_inst, 0);
      chk("rst_addr", addr_debug, 0);
      chk("rst_ins", ins_to_mem, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_byte", tx_byte, 0);
      $display("reset: state checked");

      prog = {32'h20010005, HALT};
      run_load();

      prog = {};
      n = $urandom_range(1, 6);
      repeat (n) prog.push_back(rand_word());
      prog.push_back(HALT);
      run_load();

      prog = {};
      repeat (DEPTH + 2) prog.push_back(rand_word());
      run_load();

      run_mode(10, 0);
      run_mode($urandom_range(1, 15), 0);
      run_mode($urandom_range(1, 15), 1);
      run_mode($urandom_range(0, 15), 2);

      run_step(2, 0);
      run_step($urandom_range(1, 3), 1);

      do b = 8'($urandom_range(0, 255)); while (b == 8'h4C || b == 8'h43 || b == 8'h53);
      send(b);
      @(negedge clk);
      chk("ignore_stall", stall_flag, 1);
      chk("ignore_debug", debug_flag, 1);
      chk("ignore_tx_valid", tx_valid, 0);
      $display("idle: byte %0h ignored", b);
      prog = {HALT};
      run_load();

      base = wr_q.size();
      send(8'h4C);
      send(8'($urandom));
      send(8'($urandom));
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_addr", addr_debug, 0);
      chk("midrst_ins", ins_to_mem, 0);
      chk("midrst_debug", debug_flag, 1);
      chk("midrst_stall", stall_flag, 1);
      chk("midrst_tx_valid", tx_valid, 0);
      chk("midrst_no_wea", 64'(wr_q.size() - base), 0);
      $display("reset during load: partial word discarded");
      prog = {rand_word(), HALT};
      run_load();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
